// File: rtl/byte_word_packer.sv
// byte_word_packer: merges loader byte writes into 16-bit words with byte
// enables, queues finished words in a small FIFO and drains them to a 16-bit
// memory port through a req/ack handshake.
module byte_word_packer #(
  parameter int ADDRESS_SIZE    = 14,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int FLUSH_TIMEOUT   = 16
) (
  input  logic                    clk_74a,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic [ADDRESS_SIZE:0]   write_addr,
  input  logic [7:0]              write_data,
  input  logic                    flush,
  output logic                    mem_req,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [15:0]             mem_data,
  output logic [1:0]              mem_be,
  input  logic                    mem_ack,
  output logic                    overflow,
  output logic                    busy
);
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int NW    = FIFO_DEPTH_LOG2 + 1;
  localparam int FW    = FIFO_DEPTH_LOG2 + 2;
  localparam int CW    = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0] addr;
    logic [15:0]             data;
    logic [1:0]              be;
  } word_t;

  logic                    pend_vld;
  word_t                   pend;
  logic [CW-1:0]           tmo_cnt;
  word_t                   fifo_mem [DEPTH];
  logic [PW-1:0]           rd_ptr, wr_ptr, wr_ptr1;
  logic [NW-1:0]           count;

  logic [ADDRESS_SIZE-1:0] waddr;
  word_t                   merged, nxt, word_a, word_b, head;
  logic                    nxt_vld, push_a, push_b, pop;
  logic [CW-1:0]           nxt_cnt;
  logic [FW-1:0]           free;
  logic [1:0]              n_push, n_acc;

  assign waddr   = write_addr[ADDRESS_SIZE:1];
  assign wr_ptr1 = wr_ptr + PW'(1);

  // Incoming byte folded into the pending word, or into a fresh word when the
  // pending one is empty or belongs to another address.
  always_comb begin
    merged = pend;
    if (!pend_vld || pend.addr != waddr) begin
      merged.addr = waddr;
      merged.data = '0;
      merged.be   = '0;
    end
    if (write_addr[0]) begin
      merged.data[15:8] = write_data;
      merged.be[1]      = 1'b1;
    end else begin
      merged.data[7:0]  = write_data;
      merged.be[0]      = 1'b1;
    end
  end

  // Pending-word update and up to two pushes; word_a is always the older one.
  always_comb begin
    nxt_vld = pend_vld;
    nxt     = pend;
    nxt_cnt = tmo_cnt;
    push_a  = 1'b0;
    push_b  = 1'b0;
    word_a  = pend;
    word_b  = pend;
    if (write_en) begin
      nxt_cnt = '0;
      if (pend_vld && pend.addr != waddr) push_a = 1'b1;
      // A fresh word carries one lane only, so 2'b11 implies a same-word merge.
      if (merged.be == 2'b11) begin
        push_a  = 1'b1;
        word_a  = merged;
        nxt_vld = 1'b0;
      end else begin
        nxt_vld = 1'b1;
        nxt     = merged;
      end
    end else if (pend_vld && FLUSH_TIMEOUT != 0) begin
      // Fire on the FLUSH_TIMEOUT-th idle edge after the last write.
      if (tmo_cnt == CW'(FLUSH_TIMEOUT - 1)) begin
        push_a  = 1'b1;
        nxt_vld = 1'b0;
      end else begin
        nxt_cnt = tmo_cnt + CW'(1);
      end
    end
    if (flush && nxt_vld) begin
      if (push_a) begin
        push_b = 1'b1;
        word_b = nxt;
      end else begin
        push_a = 1'b1;
        word_a = nxt;
      end
      nxt_vld = 1'b0;
    end
    if (!nxt_vld) nxt_cnt = '0;
  end

  // FIFO admission: slots free after a same-cycle pop; newest push dropped first.
  always_comb begin
    pop    = mem_ack && (count != '0);
    free   = FW'(DEPTH) - FW'(count) + FW'(pop);
    n_push = {1'b0, push_a} + {1'b0, push_b};
    n_acc  = (FW'(n_push) > free) ? free[1:0] : n_push;
  end

  // Pending register, timeout counter, FIFO pointers and sticky overflow.
  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend     <= '0;
      tmo_cnt  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      pend_vld <= nxt_vld;
      pend     <= nxt;
      tmo_cnt  <= nxt_cnt;
      wr_ptr   <= wr_ptr + PW'(n_acc);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count    <= count + NW'(n_acc) - NW'(pop);
      if (n_push != n_acc) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written since outputs are gated.
  always_ff @(posedge clk_74a) begin
    if (n_acc != 2'd0) fifo_mem[wr_ptr]  <= word_a;
    if (n_acc == 2'd2) fifo_mem[wr_ptr1] <= word_b;
  end

  assign head     = fifo_mem[rd_ptr];
  assign mem_req  = (count != '0);
  assign mem_addr = mem_req ? head.addr : '0;
  assign mem_data = mem_req ? head.data : '0;
  assign mem_be   = mem_req ? head.be   : '0;
  assign busy     = pend_vld || mem_req;

endmodule
